dram_burst_ctrl: RTL and testbench

Parametrised single-port data memory with a request/ready command interface and burst transfers. Bursts auto-increment the address for row/column streaming into the matrix-multiply datapath. Read latency is configurable. It is the generalised successor to the fixed 256x16 DRAM macro. Matrix load and store engines sit upstream; the MAC array consumes rd_data.

---
 rtl/dram_burst_ctrl_if.sv | 31 +++
 rtl/dram_burst_ctrl.sv | 153 +++++++++++++++
 tb/tb_dram_burst_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dram_burst_ctrl_if.sv
// Command, write-beat and read-beat bundle for dram_burst_ctrl.
// The master side is the upstream matrix load/store engine. The slave side is the memory.
interface dram_burst_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 4
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [LEN_W-1:0]  req_len;
    logic [DATA_W-1:0] wr_data;
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_last;
    logic              busy;
    logic              wrap;

    modport master (
        output req_valid, req_write, req_addr, req_len, wr_data, wr_valid,
        input  req_ready, wr_ready, rd_data, rd_valid, rd_last, busy, wrap
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_len, wr_data, wr_valid,
        output req_ready, wr_ready, rd_data, rd_valid, rd_last, busy, wrap
    );
endinterface

// File: rtl/dram_burst_ctrl.sv
// Single-port burst data memory with a request/ready command port.
// Bursts auto-increment the address modulo DEPTH. Reads have a fixed
// RD_LAT-cycle pipeline and arrive back-to-back with no backpressure.
module dram_burst_ctrl #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 8,
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 16
) (
    input  logic             clock,
    input  logic             reset,
    dram_burst_ctrl_if.slave bus
);
    localparam int          LEN_W = $clog2(MAX_BURST);
    localparam int          DEPTH = 1 << ADDR_W;
    localparam int unsigned LAT   = RD_LAT;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic [LEN_W-1:0]  count;

    logic              accept;
    logic              wr_en;
    logic              issue;
    logic              step;
    logic              last_beat;
    logic              pending;
    logic              req_ready_c;
    logic              wr_ready_c;

    logic [DATA_W-1:0] mem       [DEPTH];
    logic [DATA_W-1:0] pipe_data [RD_LAT];
    logic              pipe_vld  [RD_LAT];
    logic              pipe_last [RD_LAT];

    assign last_beat = (count == len);
    assign step      = wr_en | issue;

    // Beats still travelling through the stages ahead of the output register.
    // The beat already at the output needs no further cycles, so DRAIN may exit while it is shown.
    always_comb begin
        pending = 1'b0;
        for (int unsigned i = 0; i < LAT - 1; i++) begin
            pending = pending | pipe_vld[i];
        end
    end

    // Next-state and handshake decode.
    always_comb begin
        state_nxt   = state;
        req_ready_c = 1'b0;
        wr_ready_c  = 1'b0;
        accept      = 1'b0;
        wr_en       = 1'b0;
        issue       = 1'b0;
        case (state)
            IDLE: begin
                req_ready_c = 1'b1;
                if (bus.req_valid) begin
                    accept    = 1'b1;
                    state_nxt = bus.req_write ? WRITE : READ;
                end
            end
            WRITE: begin
                wr_ready_c = 1'b1;
                if (bus.wr_valid) begin
                    wr_en = 1'b1;
                    if (last_beat) begin
                        state_nxt = IDLE;
                    end
                end
            end
            READ: begin
                issue = 1'b1;
                if (last_beat) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (!pending) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register plus burst address and beat counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            addr  <= '0;
            len   <= '0;
            count <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                addr  <= bus.req_addr;
                len   <= bus.req_len;
                count <= '0;
            end else if (step) begin
                addr  <= addr + ADDR_W'(1);
                count <= count + LEN_W'(1);
            end
        end
    end

    // Storage array. It is not cleared by reset, and writes are suppressed during the reset cycle.
    always_ff @(posedge clock) begin
        if (wr_en && !reset) begin
            mem[addr] <= bus.wr_data;
        end
    end

    // Read pipeline. Stage 0 is the array read, and each later stage adds one cycle of latency.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < LAT; i++) begin
                pipe_vld[i]  <= 1'b0;
                pipe_last[i] <= 1'b0;
                pipe_data[i] <= '0;
            end
        end else begin
            pipe_vld[0]  <= issue;
            pipe_last[0] <= issue & last_beat;
            if (issue) begin
                pipe_data[0] <= mem[addr];
            end
            for (int unsigned i = 1; i < LAT; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_last[i] <= pipe_last[i-1];
                pipe_data[i] <= pipe_data[i-1];
            end
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.wr_ready  = wr_ready_c;
    assign bus.rd_valid  = pipe_vld[RD_LAT-1];
    assign bus.rd_last   = pipe_last[RD_LAT-1];
    assign bus.rd_data   = pipe_data[RD_LAT-1];
    assign bus.busy      = (state != IDLE);
    assign bus.wrap      = step && (addr == '1);
endmodule

// File: tb/tb_dram_burst_ctrl.sv
// Bench for dram_burst_ctrl. It runs four instances with RD_LAT = 1..4 from shared stimulus.
// A reference memory produces the expected read beats. These are queued per instance when
// a read is issued and popped when the instance presents rd_valid.
module tb_dram_burst_ctrl;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [7:0]  req_addr  = '0;
    logic [3:0]  req_len   = '0;
    logic [15:0] wr_data   = '0;
    logic        wr_valid  = 1'b0;

    logic [3:0]  req_ready_a, wr_ready_a, rd_valid_a, rd_last_a, busy_a, wrap_a;
    logic [15:0] rd_data_a [4];

    typedef struct {
        logic [15:0] data;
        logic        last;
        logic        first;
    } exp_t;

    exp_t        exp_q [4][$];
    logic [15:0] model [256];
    logic [15:0] wbuf  [16];
    int          checks = 0;
    int          passes = 0;
    int          cyc = 0;
    int          t_acc = 0;
    int          last_cyc [4];
    int          wrap_cnt = 0;

    always #5 clock = ~clock;

    always @(posedge clock) cyc++;

    for (genvar g = 0; g < 4; g++) begin : lat
        dram_burst_ctrl_if #(.DATA_W(16), .ADDR_W(8), .LEN_W(4)) bus ();
        assign bus.req_valid = req_valid;
        assign bus.req_write = req_write;
        assign bus.req_addr  = req_addr;
        assign bus.req_len   = req_len;
        assign bus.wr_data   = wr_data;
        assign bus.wr_valid  = wr_valid;
        assign req_ready_a[g] = bus.req_ready;
        assign wr_ready_a[g]  = bus.wr_ready;
        assign rd_valid_a[g]  = bus.rd_valid;
        assign rd_last_a[g]   = bus.rd_last;
        assign rd_data_a[g]   = bus.rd_data;
        assign busy_a[g]      = bus.busy;
        assign wrap_a[g]      = bus.wrap;

        dram_burst_ctrl #(.DATA_W(16), .ADDR_W(8), .RD_LAT(g + 1), .MAX_BURST(16)) u_dut (
            .clock (clock),
            .reset (reset),
            .bus   (bus)
        );
    end

    // Scoreboard: compare every read beat against the oldest expected beat.
    always @(negedge clock) begin
        if (!reset) begin
            if (wrap_a[0]) wrap_cnt++;
            for (int g = 0; g < 4; g++) begin
                if (rd_valid_a[g]) begin
                    checks++;
                    if (exp_q[g].size() == 0) begin
                        $display("FAIL rd_unexpected lat=%0d: got beat data=%h, required none", g + 1, rd_data_a[g]);
                    end else begin
                        exp_t e;
                        e = exp_q[g].pop_front();
                        if (rd_data_a[g] !== e.data || rd_last_a[g] !== e.last ||
                            (!e.first && cyc != last_cyc[g] + 1)) begin
                            $display("FAIL rd_beat lat=%0d: got data=%h last=%b gap=%0d, required data=%h last=%b gap=1",
                                     g + 1, rd_data_a[g], rd_last_a[g], cyc - last_cyc[g], e.data, e.last);
                        end else begin
                            passes++;
                        end
                    end
                    last_cyc[g] = cyc;
                end
            end
        end
    end

    task automatic send_cmd(input logic w, input logic [7:0] a, input logic [3:0] len);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_len   = len;
        @(posedge clock);
        #1;
        t_acc     = cyc;
        req_valid = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [3:0] len, input int gap_beat, input bit poke);
        int beat = 0;
        int n    = 0;
        int bad  = 0;
        bit gap_done = 0;
        bit hs;
        send_cmd(1'b1, a, len);
        while (beat <= int'(len) && n < 100) begin
            if (beat == gap_beat && !gap_done) begin
                wr_valid = 1'b0;
                wr_data  = 16'hDEAD;
                gap_done = 1;
            end else begin
                wr_valid = 1'b1;
                wr_data  = wbuf[beat];
            end
            if (poke) begin
                req_valid = (beat < int'(len));
                req_write = 1'b1;
                req_addr  = 8'd64;
                req_len   = 4'd0;
                if (req_ready_a[0] !== 1'b0) bad++;
            end
            hs = wr_valid && wr_ready_a[0];
            @(posedge clock);
            #1;
            req_valid = 1'b0;
            if (hs) begin
                model[a + 8'(beat)] = wbuf[beat];
                beat++;
            end
            n++;
        end
        wr_valid = 1'b0;
        checks++;
        if (n >= 100) $display("FAIL write_timeout: got %0d beats, required %0d", beat, int'(len) + 1);
        else passes++;
        if (poke) begin
            checks++;
            if (bad !== 0) $display("FAIL req_ready_busy: got %0d cycles with req_ready=1, required 0", bad);
            else passes++;
        end
    endtask

    task automatic do_read(input logic [7:0] a, input logic [3:0] len);
        for (int g = 0; g < 4; g++) begin
            for (int i = 0; i <= int'(len); i++) begin
                exp_t e;
                e.data  = model[a + 8'(i)];
                e.last  = (i == int'(len));
                e.first = (i == 0);
                exp_q[g].push_back(e);
            end
        end
        send_cmd(1'b0, a, len);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy_a != 4'b0000 && n < 64) begin
            @(posedge clock);
            #1;
            n++;
        end
        checks++;
        if (busy_a != 4'b0000) $display("FAIL idle_timeout: got busy=%b, required 0000", busy_a);
        else passes++;
        @(posedge clock);
        #1;
        for (int g = 0; g < 4; g++) begin
            checks++;
            if (exp_q[g].size() != 0) $display("FAIL beats_missing lat=%0d: got %0d outstanding, required 0", g + 1, exp_q[g].size());
            else passes++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        for (int g = 0; g < 4; g++) begin
            checks++;
            if ({req_ready_a[g], wr_ready_a[g], rd_valid_a[g], rd_last_a[g], busy_a[g], wrap_a[g]} !== 6'b100000 ||
                rd_data_a[g] !== 16'h0000) begin
                $display("FAIL reset_outputs lat=%0d: got rr,wr,rv,rl,busy,wrap=%b%b%b%b%b%b data=%h, required 100000 data=0000",
                         g + 1, req_ready_a[g], wr_ready_a[g], rd_valid_a[g], rd_last_a[g], busy_a[g], wrap_a[g], rd_data_a[g]);
            end else begin
                passes++;
            end
        end
    endtask

    task automatic test_single_beat();
        wbuf[0] = 16'd32;
        do_write(8'd5, 4'd0, -1, 0);
        checks++;
        if (req_ready_a[0] !== 1'b1) $display("FAIL write_done_ready: got %b, required 1", req_ready_a[0]);
        else passes++;
        do_read(8'd5, 4'd0);
        checks++;
        if (rd_valid_a[0] !== 1'b0) $display("FAIL single_early: got rd_valid=%b, required 0", rd_valid_a[0]);
        else passes++;
        @(posedge clock);
        #1;
        checks++;
        if (rd_valid_a[0] !== 1'b1 || rd_data_a[0] !== 16'd32 || rd_last_a[0] !== 1'b1)
            $display("FAIL single_read: got v=%b d=%h l=%b, required v=1 d=0020 l=1", rd_valid_a[0], rd_data_a[0], rd_last_a[0]);
        else passes++;
        wait_idle();
    endtask

    task automatic test_burst_gap();
        for (int i = 0; i < 4; i++) wbuf[i] = 16'h00A0 + 16'(i);
        do_write(8'd16, 4'd3, 2, 0);
        do_read(8'd16, 4'd3);
        wait_idle();
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 4; i++) wbuf[i] = 16'(i + 1);
        wrap_cnt = 0;
        do_write(8'd254, 4'd3, -1, 0);
        checks++;
        if (wrap_cnt !== 1) $display("FAIL wrap_write: got %0d pulses, required 1", wrap_cnt);
        else passes++;
        wrap_cnt = 0;
        do_read(8'd254, 4'd3);
        wait_idle();
        checks++;
        if (wrap_cnt !== 1) $display("FAIL wrap_read: got %0d pulses, required 1", wrap_cnt);
        else passes++;
    endtask

    task automatic test_latency_sweep();
        int first_seen [4];
        int busy_drop  [4];
        for (int i = 0; i < 8; i++) wbuf[i] = 16'h0100 + 16'(i);
        do_write(8'd0, 4'd7, -1, 0);
        do_read(8'd0, 4'd7);
        for (int g = 0; g < 4; g++) begin
            first_seen[g] = -1;
            busy_drop[g]  = -1;
        end
        for (int n = 1; n <= 30; n++) begin
            @(posedge clock);
            #1;
            for (int g = 0; g < 4; g++) begin
                if (first_seen[g] < 0 && rd_valid_a[g]) first_seen[g] = n;
                if (busy_drop[g] < 0 && !busy_a[g]) busy_drop[g] = n;
            end
        end
        for (int g = 0; g < 4; g++) begin
            checks++;
            if (first_seen[g] != g + 1) $display("FAIL first_valid lat=%0d: got %0d cycles, required %0d", g + 1, first_seen[g], g + 1);
            else passes++;
            checks++;
            if (busy_drop[g] != 8 + g + 1) $display("FAIL busy_span lat=%0d: got %0d cycles, required %0d", g + 1, busy_drop[g], 8 + g + 1);
            else passes++;
        end
        wait_idle();
    endtask

    task automatic test_reset_mid_read();
        int stray = 0;
        do_read(8'd0, 4'd7);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        for (int g = 0; g < 4; g++) exp_q[g].delete();
        @(posedge clock);
        #1;
        reset = 1'b0;
        for (int g = 0; g < 4; g++) begin
            checks++;
            if (rd_valid_a[g] !== 1'b0 || req_ready_a[g] !== 1'b1 || busy_a[g] !== 1'b0)
                $display("FAIL mid_reset lat=%0d: got rv=%b rr=%b busy=%b, required 0 1 0", g + 1, rd_valid_a[g], req_ready_a[g], busy_a[g]);
            else passes++;
        end
        repeat (10) begin
            @(posedge clock);
            #1;
            if (rd_valid_a != 4'b0000) stray++;
        end
        checks++;
        if (stray != 0) $display("FAIL stray_beats: got %0d cycles with rd_valid, required 0", stray);
        else passes++;
        do_read(8'd16, 4'd3);
        wait_idle();
    endtask

    task automatic test_cmd_ignore();
        wbuf[0] = 16'h5555;
        do_write(8'd64, 4'd0, -1, 0);
        for (int i = 0; i < 4; i++) wbuf[i] = 16'h00C0 + 16'(i);
        do_write(8'd32, 4'd3, -1, 1);
        @(posedge clock);
        #1;
        checks++;
        if (busy_a !== 4'b0000) $display("FAIL cmd_queued: got busy=%b, required 0000", busy_a);
        else passes++;
        do_read(8'd32, 4'd3);
        wait_idle();
        do_read(8'd64, 4'd0);
        wait_idle();
    endtask

    initial begin
        for (int g = 0; g < 4; g++) last_cyc[g] = 0;
        test_reset();
        test_single_beat();
        test_burst_gap();
        test_wrap();
        test_latency_sweep();
        test_reset_mid_read();
        test_cmd_ignore();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, required finish before 200000");
        $fatal(1, "watchdog");
    end
endmodule
